// File: rtl/sample04_sched.sv
// Scheduled evaluator for a small logic network on ALUS shared 2-input units (ALUS = 1 or 2).
// Optional op_count output is enabled by defining SAMPLE04_SCHED_OPCOUNT_EN.
module sample04_sched #(
    parameter int unsigned ALUS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        x,
    input  logic        y,
    input  logic        z,
    input  logic        u,
    input  logic        v,
    input  logic        w,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        r,
    output logic        s,
    output logic        t
`ifdef SAMPLE04_SCHED_OPCOUNT_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int unsigned STEP_W    = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned FN_W      = 2;
    localparam int unsigned LAST_STEP = (ALUS == 2) ? 4 : 8;

    localparam logic [FN_W-1:0] FN_AND = FN_W'(0);
    localparam logic [FN_W-1:0] FN_OR  = FN_W'(1);
    localparam logic [FN_W-1:0] FN_NOT = FN_W'(2);

    if (!(ALUS == 1 || ALUS == 2)) begin : g_bad_alus
        $error("sample04_sched: ALUS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step;
    logic                last_step;
    logic                accept;
    logic                ready_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    logic x_q, y_q, z_q, u_q, v_q, w_q;
    logic a_q, n_q, p_q, q_q, b_q, m_q, r_q, s_q, t_q;
    logic a_nxt, n_nxt, p_nxt, q_nxt, b_nxt, m_nxt, r_nxt, s_nxt, t_nxt;

    logic [OP_W-1:0] slot_op  [ALUS];
    logic [FN_W-1:0] slot_fn  [ALUS];
    logic            slot_a   [ALUS];
    logic            slot_b   [ALUS];
    logic            slot_res [ALUS];

    // Schedule table: operation number (1..9, 0 = idle slot) for a step and ALU slot.
    function automatic logic [OP_W-1:0] sched_op(input logic [STEP_W-1:0] st, input int unsigned slot);
        logic [OP_W-1:0] op;
        op = '0;
        if (ALUS == 1) begin
            case (st)
                STEP_W'(0): op = OP_W'(1);
                STEP_W'(1): op = OP_W'(5);
                STEP_W'(2): op = OP_W'(2);
                STEP_W'(3): op = OP_W'(6);
                STEP_W'(4): op = OP_W'(3);
                STEP_W'(5): op = OP_W'(4);
                STEP_W'(6): op = OP_W'(7);
                STEP_W'(7): op = OP_W'(8);
                STEP_W'(8): op = OP_W'(9);
                default:    op = '0;
            endcase
        end else if (slot == 0) begin
            case (st)
                STEP_W'(0): op = OP_W'(1);
                STEP_W'(1): op = OP_W'(2);
                STEP_W'(2): op = OP_W'(3);
                STEP_W'(3): op = OP_W'(4);
                STEP_W'(4): op = OP_W'(7);
                default:    op = '0;
            endcase
        end else begin
            case (st)
                STEP_W'(0): op = OP_W'(5);
                STEP_W'(1): op = OP_W'(6);
                STEP_W'(2): op = OP_W'(8);
                STEP_W'(3): op = OP_W'(9);
                default:    op = '0;
            endcase
        end
        return op;
    endfunction

    function automatic logic alu(input logic [FN_W-1:0] fn, input logic ia, input logic ib);
        logic res;
        case (fn)
            FN_AND:  res = ia & ib;
            FN_OR:   res = ia | ib;
            FN_NOT:  res = ~ia;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign last_step = (step == STEP_W'(LAST_STEP));
    assign accept    = start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            EXEC: begin
                ready_nxt = 1'b0;
                busy_nxt  = 1'b1;
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= ready_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Per-slot operand routing into the shared units
    always_comb begin
        for (int i = 0; i < int'(ALUS); i++) begin
            slot_op[i] = (state == EXEC) ? sched_op(step, i) : '0;
            slot_fn[i] = FN_AND;
            slot_a[i]  = 1'b0;
            slot_b[i]  = 1'b0;
            case (slot_op[i])
                OP_W'(1): begin slot_fn[i] = FN_AND; slot_a[i] = x_q; slot_b[i] = y_q; end
                OP_W'(2): begin slot_fn[i] = FN_AND; slot_a[i] = a_q; slot_b[i] = z_q; end
                OP_W'(3): begin slot_fn[i] = FN_OR;  slot_a[i] = n_q; slot_b[i] = u_q; end
                OP_W'(4): begin slot_fn[i] = FN_OR;  slot_a[i] = p_q; slot_b[i] = w_q; end
                OP_W'(5): begin slot_fn[i] = FN_OR;  slot_a[i] = v_q; slot_b[i] = x_q; end
                OP_W'(6): begin slot_fn[i] = FN_OR;  slot_a[i] = b_q; slot_b[i] = y_q; end
                OP_W'(7): begin slot_fn[i] = FN_AND; slot_a[i] = q_q; slot_b[i] = m_q; end
                OP_W'(8): begin slot_fn[i] = FN_AND; slot_a[i] = u_q; slot_b[i] = w_q; end
                OP_W'(9): begin slot_fn[i] = FN_NOT; slot_a[i] = z_q; slot_b[i] = 1'b0; end
                default:  ;
            endcase
            slot_res[i] = alu(slot_fn[i], slot_a[i], slot_b[i]);
        end
    end

    // Result write-back to the destination register of each slot's operation
    always_comb begin
        a_nxt = a_q; n_nxt = n_q; p_nxt = p_q; q_nxt = q_q; b_nxt = b_q;
        m_nxt = m_q; r_nxt = r_q; s_nxt = s_q; t_nxt = t_q;
        for (int i = 0; i < int'(ALUS); i++) begin
            case (slot_op[i])
                OP_W'(1): a_nxt = slot_res[i];
                OP_W'(2): n_nxt = slot_res[i];
                OP_W'(3): p_nxt = slot_res[i];
                OP_W'(4): q_nxt = slot_res[i];
                OP_W'(5): b_nxt = slot_res[i];
                OP_W'(6): m_nxt = slot_res[i];
                OP_W'(7): r_nxt = slot_res[i];
                OP_W'(8): s_nxt = slot_res[i];
                OP_W'(9): t_nxt = slot_res[i];
                default:  ;
            endcase
        end
    end

    // Operand capture, step counter, intermediates and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            {x_q, y_q, z_q, u_q, v_q, w_q} <= '0;
            {a_q, n_q, p_q, q_q, b_q, m_q, r_q, s_q, t_q} <= '0;
            {r, s, t} <= '0;
        end else begin
            if (accept) begin
                step <= '0;
                {x_q, y_q, z_q, u_q, v_q, w_q} <= {x, y, z, u, v, w};
            end else if (state == EXEC) begin
                step <= step + STEP_W'(1);
            end
            {a_q, n_q, p_q, q_q, b_q, m_q, r_q, s_q, t_q} <=
                {a_nxt, n_nxt, p_nxt, q_nxt, b_nxt, m_nxt, r_nxt, s_nxt, t_nxt};
            if ((state == EXEC) && last_step) {r, s, t} <= {r_nxt, s_nxt, t_nxt};
        end
    end

`ifdef SAMPLE04_SCHED_OPCOUNT_EN
    logic [1:0] ops_now;

    always_comb begin
        ops_now = '0;
        for (int i = 0; i < int'(ALUS); i++) begin
            if (slot_op[i] != '0) ops_now = ops_now + 2'd1;
        end
    end

    // Saturating count of executed operations
    always_ff @(posedge clk) begin
        if (rst)                                     op_count <= '0;
        else if (op_count > (16'hFFFF - 16'(ops_now))) op_count <= 16'hFFFF;
        else                                         op_count <= op_count + 16'(ops_now);
    end
`endif

endmodule

// File: doc/sample04_sched.md
SAMPLE04_SCHED -- requirements
Module: sample04_sched

Interface
REQ-001 Parameter: ALUS, default 1, number of shared 2-input logic units; legal values 1 or 2; any other value SHALL fail elaboration.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to evaluate one operand set.
REQ-005 x, y, z, u, v, w  input  1 each  operands, sampled only when start is accepted.
REQ-006 ready  output  1  high when start will be accepted this cycle.
REQ-007 busy  output  1  high while the schedule is executing.
REQ-008 done  output  1  one-cycle pulse; r, s, t are valid from this cycle.
REQ-009 r, s, t  output  1 each  registered results; held until the next completion.

Function
REQ-010 The block SHALL compute n=x&y&z, p=n|u, q=p|w, m=v|x|y, r=q&m, s=u&w, t=!z as nine operations: O1 a=x&y; O2 n=a&z; O3 p=n|u; O4 q=p|w; O5 b=v|x; O6 m=b|y; O7 r=q&m; O8 s=u&w; O9 t=!z.
REQ-011 At most ALUS operations SHALL execute per cycle; intermediates (a, n, p, q, b, m) and results SHALL be held in registers.
REQ-012 ALUS=1 schedule SHALL be 9 steps, one per cycle, in order O1,O5,O2,O6,O3,O4,O7,O8,O9.
REQ-013 ALUS=2 schedule SHALL be 5 steps: {O1,O5}, {O2,O6}, {O3,O8}, {O4,O9}, {O7}.
REQ-014 FSM states: IDLE, EXEC, DONE; a step counter SHALL index the current schedule step.
REQ-015 IDLE: ready=1, busy=0; start=1 captures operands, clears step counter, moves to EXEC.
REQ-016 EXEC: ready=0, busy=1; one step per cycle; after the final step, moves to DONE.
REQ-017 DONE: done=1, ready=1, busy=0 for exactly one cycle; start=1 SHALL be accepted (capture, go to EXEC), else go to IDLE.
REQ-018 Latency: start accepted in cycle k -> done=1 in cycle k+S+1, S=9 (ALUS=1) or 5 (ALUS=2).
REQ-019 r, s, t SHALL update only on the edge that enters DONE; they SHALL not change during EXEC.
REQ-020 start while busy=1 SHALL be ignored without side effects; operand changes during EXEC SHALL not affect results.
REQ-021 Back-to-back start (held high) SHALL yield one done every S+1 cycles.

Reset
REQ-022 rst=1 on an edge SHALL force IDLE, step counter 0, all intermediates 0, r=s=t=0, done=0, busy=0, ready=1.
REQ-023 rst asserted mid-EXEC SHALL abort the operation with no done pulse; rst has priority over start.
REQ-024 First start SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-025 Macro SAMPLE04_SCHED_OPCOUNT_EN: when defined, the block SHALL add output op_count (16 bits) counting operations executed (+1 or +2 per EXEC cycle), saturating at 0xFFFF, cleared only by rst.
REQ-026 Without SAMPLE04_SCHED_OPCOUNT_EN, op_count and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-027 ALUS=1, x=y=z=1, u=v=w=0, start pulse at k -> done at k+10, r=1, s=0, t=0.
REQ-028 ALUS=2, x=1, y=z=u=v=w=0 -> done at k+6, r=0, s=0, t=1.
REQ-029 ALUS=2, u=w=1, x=y=z=v=0 -> r=0, s=1, t=1; r/s/t unchanged before done cycle.
REQ-030 start held high for 3 operations -> done pulses S+1 cycles apart; start pulses during EXEC ignored; operands toggled mid-EXEC do not change results.
REQ-031 rst asserted at step 3 of EXEC -> no done, r=s=t=0, ready=1 next cycle; new start completes normally.
REQ-032 With SAMPLE04_SCHED_OPCOUNT_EN, two operations at ALUS=1 -> op_count=18; preloaded near-max run saturates at 0xFFFF.
